// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between the MEM stage and the data memory responder.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency doubleword data memory with IDLE/BUSY/RESP handshake FSM.
// Define DMEM_MISALIGN_ERR_EN to fault requests whose addr[2:0] is non-zero.
module data_mem_responder #(
    parameter int unsigned ADDR_BITS = 6,
    parameter int unsigned LATENCY   = 2
) (
    input logic                 CLK,
    input logic                 reset,
    data_mem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q;
    logic                   cap_write_q;
    logic [ADDR_BITS-1:0]   cap_idx_q;
    logic [63:0]            cap_wdata_q;
    logic [63:0]            rdata_q;
    logic [63:0]            mem [0:(1<<ADDR_BITS)-1];
    logic                   accept;
    logic                   commit;
    logic                   misalign;
    logic                   unused_addr;

    assign accept      = (state_q == IDLE) && bus.req_valid;
    assign commit      = (state_q == BUSY) && (cnt_q == '0);
    assign unused_addr = ^{bus.req_addr[63:ADDR_BITS+3], bus.req_addr[2:0]};

`ifdef DMEM_MISALIGN_ERR_EN
    logic [2:0] cap_lo_q;
    logic       err_q;

    assign misalign    = (cap_lo_q != 3'd0);
    assign bus.rsp_err = err_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            cap_lo_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept)
                cap_lo_q <= bus.req_addr[2:0];
            if (commit)
                err_q <= misalign;
            else if ((state_q == RESP) && bus.rsp_ready)
                err_q <= 1'b0;
        end
    end
`else
    assign misalign    = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = BUSY;
            BUSY:    if (cnt_q == '0)   state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            cnt_q       <= '0;
            cap_write_q <= 1'b0;
            cap_idx_q   <= '0;
            cap_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            if (accept) begin
                cnt_q       <= 4'(LATENCY - 1);
                cap_write_q <= bus.req_write;
                cap_idx_q   <= bus.req_addr[ADDR_BITS+2:3];
                cap_wdata_q <= bus.req_wdata;
            end else if ((state_q == BUSY) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 4'd1;
            end

            if (commit)
                rdata_q <= (cap_write_q || misalign) ? '0 : mem[cap_idx_q];
            else if ((state_q == RESP) && bus.rsp_ready)
                rdata_q <= '0;
        end
    end

    // No reset on the array; a reset on the commit edge must still suppress the store.
    always_ff @(posedge CLK) begin
        if (!reset && commit && cap_write_q && !misalign)
            mem[cap_idx_q] <= cap_wdata_q;
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
endmodule
